// File: rtl/rcastudio_pkg.sv
// Shared declarations for the Studio II core.
//   upl_state_t     : upload server sequencer states
//   UPL_FILL_BYTE   : byte returned for addresses outside core memory
//   UPL_IDX_CARTRAM : ioctl_index of the cartridge RAM save slot
package rcastudio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } upl_state_t;

  localparam logic [7:0] UPL_FILL_BYTE   = 8'hFF;
  localparam logic [7:0] UPL_IDX_CARTRAM = 8'h01;

endpackage

// File: rtl/ioctl_upload_server.sv
// HPS upload server: answers ioctl_rd strobes of a matching upload session
// with bytes fetched from core memory over a req/ack port.
//
// Ports
//   clk, reset_n              : core clock, asynchronous active-low reset
//   ioctl_upload, ioctl_index : session control from the HPS
//   ioctl_rd, ioctl_addr      : single-cycle read strobe and byte address
//   ioctl_din, ioctl_wait     : returned byte and host stall
//   mem_req, mem_addr         : memory read request, held until mem_ack
//   mem_ack, mem_rdata        : one-cycle acknowledge with data
//   active, done              : session selected / one-cycle end-of-session pulse
//   byte_count                : bytes served this session (saturating)
module ioctl_upload_server
  import rcastudio_pkg::*;
#(
  parameter logic [7:0] UPLOAD_INDEX = UPL_IDX_CARTRAM,
  parameter int         MEM_SIZE     = 4096,
  parameter int         AW           = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic          active,
  output logic          done,
  output logic [24:0]   byte_count
);

  localparam logic [24:0] MEM_LIMIT = 25'(MEM_SIZE);

  function automatic logic [24:0] sat_inc(input logic [24:0] v);
    return (&v) ? v : v + 25'd1;
  endfunction

  upl_state_t state;
  logic       aborted;
  logic       active_d;

  // Session select before the output register; used to react to a session
  // ending in the same cycle that active drops.
  assign active_d = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      aborted    <= 1'b0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
      byte_count <= '0;
    end else begin
      active <= active_d;
      done   <= active && !active_d;

      case (state)
        IDLE: begin
          if (ioctl_rd && active) begin
            ioctl_wait <= 1'b1;
            if (ioctl_addr < MEM_LIMIT) begin
              mem_addr <= ioctl_addr[AW-1:0];
              mem_req  <= 1'b1;
              aborted  <= 1'b0;
              state    <= REQ;
            end else begin
              state <= FILL;
            end
          end
        end

        REQ: begin
          // A session ending mid-request releases the host at once, but the
          // request stays up until the arbiter acks so it never sees a drop.
          if (!active_d) begin
            ioctl_wait <= 1'b0;
            aborted    <= 1'b1;
          end
          if (mem_ack) begin
            mem_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            state      <= IDLE;
            if (!aborted && active_d) begin
              ioctl_din  <= mem_rdata;
              byte_count <= sat_inc(byte_count);
            end
          end
        end

        FILL: begin
          ioctl_wait <= 1'b0;
          state      <= IDLE;
          if (active_d) begin
            ioctl_din  <= UPL_FILL_BYTE;
            byte_count <= sat_inc(byte_count);
          end
        end

        default: state <= IDLE;
      endcase

      // New session: restart the count (overrides any increment above).
      if (active_d && !active) begin
        byte_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_upload_server.sv
`timescale 1ns/1ps
module tb_ioctl_upload_server;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        active;
  logic        done;
  logic [24:0] byte_count;

  int vectors = 0;
  int errors  = 0;
  int exp_cnt = 0;
  logic [7:0] last_din = 8'h00;
  logic [7:0] exp_q[$];

  always #10.417 clk = ~clk;

  ioctl_upload_server #(
    .UPLOAD_INDEX(8'h01),
    .MEM_SIZE(4096),
    .AW(12)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .active(active),
    .done(done),
    .byte_count(byte_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One host read. ack_dly = cycles mem_ack is held off after mem_req is seen.
  task automatic read_byte(input string tag, input logic [24:0] addr,
                           input int ack_dly, input logic [7:0] data);
    logic in_range;
    logic [7:0] exp;
    in_range = (addr < 25'd4096);
    exp_q.push_back(in_range ? data : 8'hFF);
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    @(negedge clk);
    ioctl_rd   = 1'b0;
    ioctl_addr = $urandom;
    check({tag, " wait_rise"}, ioctl_wait, 1);
    check({tag, " req_rise"}, mem_req, in_range);
    if (in_range) begin
      check({tag, " mem_addr"}, mem_addr, addr[11:0]);
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        check({tag, " req_hold"}, {mem_req, ioctl_wait, mem_addr}, {2'b11, addr[11:0]});
      end
      mem_ack   = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      check({tag, " req_drop"}, mem_req, 0);
    end else begin
      @(negedge clk);
      check({tag, " no_req"}, mem_req, 0);
    end
    check({tag, " wait_drop"}, ioctl_wait, 0);
    exp = exp_q.pop_front();
    last_din = exp;
    if (exp_cnt < 33554431) exp_cnt++;
    check({tag, " din"}, ioctl_din, exp);
    check({tag, " count"}, byte_count, exp_cnt);
  endtask

  task automatic start_session();
    ioctl_upload = 1'b1;
    ioctl_index  = 8'h01;
    @(negedge clk);
    exp_cnt = 0;
    check("sess active", active, 1);
    check("sess count0", byte_count, 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'h00;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    mem_ack      = 1'b0;
    mem_rdata    = 8'h00;
    cyc(2);
    check("rst outs", {ioctl_din, ioctl_wait, mem_req, active, done}, 0);
    check("rst cnt_addr", {byte_count, mem_addr}, 0);
    reset_n = 1'b1;
    cyc(1);

    // Inactive and wrong-index strobes are ignored
    ioctl_rd = 1'b1; ioctl_addr = 25'h010;
    cyc(1);
    ioctl_rd = 1'b0;
    cyc(1);
    check("inactive", {mem_req, ioctl_wait, active}, 0);
    ioctl_upload = 1'b1; ioctl_index = 8'h02;
    cyc(2);
    ioctl_rd = 1'b1;
    cyc(1);
    ioctl_rd = 1'b0;
    cyc(1);
    check("wrong_idx", {mem_req, ioctl_wait, active}, 0);
    check("wrong_idx cnt", byte_count, 0);

    start_session();
    read_byte("imm", 25'h010, 1, 8'h5A);
    read_byte("min", 25'h011, 0, 8'hC3);
    read_byte("slow", 25'h010, 7, 8'h3C);
    read_byte("oor", 25'd4096, 0, 8'h00);
    read_byte("seq4094", 25'd4094, 2, 8'h94);
    read_byte("seq4095", 25'd4095, 0, 8'h95);
    read_byte("seq4096", 25'd4096, 0, 8'h00);
    read_byte("seq4097", 25'd4097, 0, 8'h00);
    read_byte("hi_addr", 25'h1FFFFFF, 0, 8'h00);

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 8'h99;
    cyc(1);
    mem_ack = 1'b0;
    cyc(1);
    check("stray_ack din", ioctl_din, last_din);
    check("stray_ack cnt", byte_count, exp_cnt);

    // Abort mid-request
    ioctl_rd = 1'b1; ioctl_addr = 25'h123;
    cyc(1);
    ioctl_rd = 1'b0;
    check("abort req", mem_req, 1);
    ioctl_upload = 1'b0;
    cyc(1);
    check("abort wait", {ioctl_wait, mem_req, active, done}, 4'b0101);
    cyc(1);
    check("abort hold", {mem_req, done}, 2'b10);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    cyc(1);
    mem_ack = 1'b0;
    check("abort release", mem_req, 0);
    check("abort din", ioctl_din, last_din);
    cyc(2);
    check("abort done_once", done, 0);
    check("abort cnt_hold", byte_count, exp_cnt);

    // Normal end of session
    start_session();
    read_byte("s2", 25'h020, 1, 8'hE1);
    ioctl_upload = 1'b0;
    cyc(1);
    check("end done", {active, done}, 2'b01);
    cyc(1);
    check("end done_low", done, 0);
    check("end cnt_hold", byte_count, exp_cnt);

    // Asynchronous reset during REQ
    start_session();
    ioctl_rd = 1'b1; ioctl_addr = 25'h0AB;
    cyc(1);
    ioctl_rd = 1'b0;
    check("rstmid req", mem_req, 1);
    #3 reset_n = 1'b0;
    #1;
    check("rstmid outs", {ioctl_din, ioctl_wait, mem_req, active, done}, 0);
    check("rstmid cnt_addr", {byte_count, mem_addr}, 0);
    last_din = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    ioctl_upload = 1'b0;
    cyc(1);
    start_session();
    read_byte("post_rst", 25'h0AB, 3, 8'h42);
    check("post_rst cnt", byte_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
